// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: replays a byte table into a UART transmitter,
// one byte per busy handshake, with a programmable idle gap between bytes.
module uart_tx_sequencer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int GAP_W  = 22
) (
    input  logic                     clk,
    input  logic                     i_reset_n,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic [$clog2(DEPTH):0]   i_len,
    input  logic [GAP_W-1:0]         i_gap,
    input  logic                     i_loop,
    input  logic                     i_start,
    input  logic                     i_stop,
    input  logic                     i_busy,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_valid,
    output logic                     o_active,
    output logic [$clog2(DEPTH)-1:0] o_index,
    output logic                     o_done
);

    localparam int IW = $clog2(DEPTH);
    localparam int LW = IW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_TX,
        S_GAP
    } state_t;

    logic [DATA_W-1:0] r_table [DEPTH];

    state_t            r_state;
    logic [IW-1:0]     r_index;
    logic [LW-1:0]     r_len;
    logic [GAP_W-1:0]  r_gap;
    logic              r_loop;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              r_stop_pend;
    logic [DATA_W-1:0] r_data;
    logic              r_done;

    state_t            w_state_nx;
    logic [IW-1:0]     w_index_nx;
    logic [LW-1:0]     w_len_nx;
    logic [GAP_W-1:0]  w_gap_nx;
    logic              w_loop_nx;
    logic [GAP_W-1:0]  w_gap_cnt_nx;
    logic              w_stop_nx;
    logic [DATA_W-1:0] w_data_nx;
    logic              w_done_nx;
    logic              w_valid;
    logic              w_last;
    logic [IW-1:0]     w_index_adv;
    logic [LW-1:0]     w_len_clamp;
    logic [DATA_W-1:0] w_rd_data;

    assign w_rd_data   = r_table[r_index];
    assign w_last      = ({1'b0, r_index} == (r_len - 1'b1));
    assign w_index_adv = (w_last && r_loop) ? '0 : r_index + 1'b1;
    assign w_len_clamp = (i_len > DEPTH_L) ? DEPTH_L : i_len;

    // Table write port, live in every state; contents survive reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_table[i_wr_addr] <= i_wr_data;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_index     <= '0;
            r_len       <= '0;
            r_gap       <= '0;
            r_loop      <= 1'b0;
            r_gap_cnt   <= '0;
            r_stop_pend <= 1'b0;
            r_data      <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_index     <= w_index_nx;
            r_len       <= w_len_nx;
            r_gap       <= w_gap_nx;
            r_loop      <= w_loop_nx;
            r_gap_cnt   <= w_gap_cnt_nx;
            r_stop_pend <= w_stop_nx;
            r_data      <= w_data_nx;
            r_done      <= w_done_nx;
        end
    end

    // Next-state and strobe logic; the strobe is gated by live i_busy
    // so it can never fire while the transmitter is occupied.
    always_comb begin
        w_state_nx   = r_state;
        w_index_nx   = r_index;
        w_len_nx     = r_len;
        w_gap_nx     = r_gap;
        w_loop_nx    = r_loop;
        w_gap_cnt_nx = r_gap_cnt;
        w_stop_nx    = r_stop_pend;
        w_data_nx    = r_data;
        w_done_nx    = 1'b0;
        w_valid      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_len != '0) begin
                        w_len_nx   = w_len_clamp;
                        w_gap_nx   = i_gap;
                        w_loop_nx  = i_loop;
                        w_index_nx = '0;
                        w_stop_nx  = 1'b0;
                        w_state_nx = S_SEND;
                    end else begin
                        w_done_nx  = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (i_stop) begin
                    w_state_nx = S_IDLE;
                    w_done_nx  = 1'b1;
                end else if (!i_busy) begin
                    w_valid    = 1'b1;
                    w_data_nx  = w_rd_data;
                    w_state_nx = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (i_stop) begin
                    w_stop_nx = 1'b1;
                end
                if (i_busy) begin
                    w_state_nx = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                if (!i_busy) begin
                    if (r_stop_pend || i_stop || (w_last && !r_loop)) begin
                        w_state_nx = S_IDLE;
                        w_done_nx  = 1'b1;
                        w_stop_nx  = 1'b0;
                    end else if (r_gap == '0) begin
                        w_index_nx = w_index_adv;
                        w_state_nx = S_SEND;
                    end else begin
                        w_gap_cnt_nx = r_gap;
                        w_state_nx   = S_GAP;
                    end
                end else if (i_stop) begin
                    w_stop_nx = 1'b1;
                end
            end
            S_GAP: begin
                if (i_stop) begin
                    w_gap_cnt_nx = '0;
                    w_state_nx   = S_IDLE;
                    w_done_nx    = 1'b1;
                end else if (r_gap_cnt <= GAP_W'(1)) begin
                    w_gap_cnt_nx = '0;
                    w_index_nx   = w_index_adv;
                    w_state_nx   = S_SEND;
                end else begin
                    w_gap_cnt_nx = r_gap_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign o_valid  = w_valid;
    assign o_data   = w_valid ? w_rd_data : r_data;
    assign o_active = (r_state != S_IDLE);
    assign o_index  = r_index;
    assign o_done   = r_done;

endmodule
